div_ctrl: RTL

Sequencer between the execute stage and the pipelined divider IP (AXI-stream style dividend/divisor/dout channels). Accepts a divide request from EXE, launches both operands exactly once, waits for the result, and holds `div_complete` until EXE retires the instruction. Handles `excp_flush`/`ertn_flush` mid-operation by draining and discarding in-flight results, so the IP never returns a stale quotient to a later instruction.

---
 rtl/div_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// Sequencer between EXE and a pipelined AXI-stream divider IP: launches each operand once,
// waits for the result and drains in-flight results after a flush. Optional macro: DIV_ZERO_BYPASS_EN.
module div_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_div_enable,
  input  logic        es_mul_div_sign,
  input  logic [31:0] es_rj_value,
  input  logic [31:0] es_rkd_value,
  input  logic        es_advance,
  input  logic        flush,
  output logic        div_complete,
  output logic [31:0] div_quotient,
  output logic [31:0] div_remainder,
  output logic        div_signed,
  output logic        dividend_tvalid,
  input  logic        dividend_tready,
  output logic [31:0] dividend_tdata,
  output logic        divisor_tvalid,
  input  logic        divisor_tready,
  output logic [31:0] divisor_tdata,
  input  logic        dout_tvalid,
  input  logic [63:0] dout_tdata,
  output logic        div_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t state, state_nxt;

  logic dvd_acc, dvs_acc;
  logic dvd_fire, dvs_fire;
  logic dvd_done, dvs_done;
  logic launch, capture;
`ifdef DIV_ZERO_BYPASS_EN
  logic bypass;
`endif

  // A channel stays valid until its own handshake, in SEND and while draining.
  assign dividend_tvalid = ((state == S_SEND) || (state == S_DRAIN)) && !dvd_acc;
  assign divisor_tvalid  = ((state == S_SEND) || (state == S_DRAIN)) && !dvs_acc;

  assign dvd_fire = dividend_tvalid && dividend_tready;
  assign dvs_fire = divisor_tvalid && divisor_tready;
  assign dvd_done = dvd_acc || dvd_fire;
  assign dvs_done = dvs_acc || dvs_fire;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    capture   = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
    bypass    = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (es_div_enable && !flush) begin
`ifdef DIV_ZERO_BYPASS_EN
          if (es_rkd_value == '0) begin
            bypass    = 1'b1;
            state_nxt = S_DONE;
          end else begin
            launch    = 1'b1;
            state_nxt = S_SEND;
          end
`else
          launch    = 1'b1;
          state_nxt = S_SEND;
`endif
        end
      end
      S_SEND: begin
        if (flush) begin
          state_nxt = (dvd_done || dvs_done) ? S_DRAIN : S_IDLE;
        end else if (dvd_done && dvs_done) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A result arriving in the flush cycle is the one DRAIN would wait for, so drop it here.
        if (flush) begin
          state_nxt = dout_tvalid ? S_IDLE : S_DRAIN;
        end else if (dout_tvalid) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (flush || es_advance) begin
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (dvd_acc && dvs_acc && dout_tvalid) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      dvd_acc      <= 1'b0;
      dvs_acc      <= 1'b0;
      div_complete <= 1'b0;
      div_busy     <= 1'b0;
    end else begin
      state        <= state_nxt;
      div_complete <= (state_nxt == S_DONE);
      div_busy     <= (state_nxt != S_IDLE);
      if (launch) begin
        dvd_acc <= 1'b0;
        dvs_acc <= 1'b0;
      end else begin
        if (dvd_fire) dvd_acc <= 1'b1;
        if (dvs_fire) dvs_acc <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dividend_tdata <= '0;
      divisor_tdata  <= '0;
      div_signed     <= 1'b0;
      div_quotient   <= '0;
      div_remainder  <= '0;
    end else begin
      if (launch) begin
        dividend_tdata <= es_rj_value;
        divisor_tdata  <= es_rkd_value;
        div_signed     <= es_mul_div_sign;
      end
      if (capture) begin
        div_quotient  <= dout_tdata[63:32];
        div_remainder <= dout_tdata[31:0];
      end
`ifdef DIV_ZERO_BYPASS_EN
      if (bypass) begin
        div_quotient  <= '0;
        div_remainder <= es_rj_value;
      end
`endif
    end
  end

endmodule
